// File: rtl/text_buf_arbiter_if.sv
// Bus bundle between the text buffer arbiter and its requesters/scanner.
// aux_req/aux_grant: aux holds req with stable ptr/char; a write happens in any cycle where req and grant are both high.
interface text_buf_arbiter_if;
   logic       host_valid;
   logic [7:0] host_byte;
   logic       aux_req;
   logic [3:0] aux_ptr;
   logic [7:0] aux_char;
   logic       aux_grant;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [3:0] wr_ptr;
   logic       busy;
   logic       ovf;
   logic       ovf_clr;
   logic       state_dbg;

   modport master (
      output host_valid, host_byte, aux_req, aux_ptr, aux_char, rd_addr, ovf_clr,
      input  aux_grant, rd_data, wr_ptr, busy, ovf, state_dbg
   );

   modport slave (
      input  host_valid, host_byte, aux_req, aux_ptr, aux_char, rd_addr, ovf_clr,
      output aux_grant, rd_data, wr_ptr, busy, ovf, state_dbg
   );
endinterface

// File: rtl/text_buf_arbiter.sv
// 16-entry LED column character buffer: round-robin host/aux writes,
// host control-character decoding, multi-cycle clear, registered read port.
module text_buf_arbiter #(
   parameter int         DEPTH = 16,
   parameter logic [7:0] FILL  = 8'h20
) (
   input  logic                 CLK12M,
   input  logic                 nrst,
   text_buf_arbiter_if.slave    bus
);
   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [7:0] buf_q [DEPTH];
   logic       hold_full_q;
   logic [7:0] hold_byte_q;
   logic       host_last_q;
   logic [3:0] wr_ptr_q, wr_ptr_d;
   logic [3:0] clr_cnt_q;
   logic       ovf_q;
   logic [7:0] rd_data_q;

   logic       grant_host, grant_aux;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       drop;

   // Service selection: round robin only matters when both sides are pending.
   always_comb begin
      grant_host = 1'b0;
      grant_aux  = 1'b0;
      if (state_q == S_IDLE) begin
         if (hold_full_q && bus.aux_req) begin
            grant_host = !host_last_q;
            grant_aux  = host_last_q;
         end else begin
            grant_host = hold_full_q;
            grant_aux  = bus.aux_req;
         end
      end
   end

   always_ff @(posedge CLK12M or negedge nrst) begin
      if (!nrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_host && hold_byte_q == 8'h1B) state_d = S_CLEAR;
         S_CLEAR: if (clr_cnt_q == 4'd15) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = clr_cnt_q;
      wr_data  = FILL;
      wr_ptr_d = wr_ptr_q;
      if (state_q == S_CLEAR) begin
         wr_en = 1'b1;
      end else if (grant_aux) begin
         wr_en   = 1'b1;
         wr_addr = bus.aux_ptr;
         wr_data = bus.aux_char;
      end else if (grant_host) begin
         if (hold_byte_q == 8'h0D || hold_byte_q == 8'h1B) begin
            wr_ptr_d = 4'd0;
         end else if (hold_byte_q == 8'h08) begin
            wr_ptr_d = wr_ptr_q - 4'd1;
            wr_en    = 1'b1;
            wr_addr  = wr_ptr_q - 4'd1;
         end else if (hold_byte_q >= 8'h20 && hold_byte_q <= 8'h7E) begin
            wr_en    = 1'b1;
            wr_addr  = wr_ptr_q;
            wr_data  = hold_byte_q;
            wr_ptr_d = wr_ptr_q + 4'd1;
         end
      end
   end

   assign bus.aux_grant = grant_aux;
   assign bus.busy      = (state_q == S_CLEAR);
   assign bus.state_dbg = (state_q == S_CLEAR);
   assign bus.wr_ptr    = wr_ptr_q;
   assign bus.ovf       = ovf_q;
   assign bus.rd_data   = rd_data_q;

   // A consume in the same cycle frees the slot, so only an unconsumed full register drops.
   assign drop = bus.host_valid && hold_full_q && !grant_host;

   always_ff @(posedge CLK12M or negedge nrst) begin
      if (!nrst) begin
         hold_full_q <= 1'b0;
         hold_byte_q <= 8'h00;
         ovf_q       <= 1'b0;
         host_last_q <= 1'b1;
         wr_ptr_q    <= 4'd0;
         clr_cnt_q   <= 4'd0;
         rd_data_q   <= FILL;
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= FILL;
      end else begin
         if (bus.host_valid && !drop) begin
            hold_full_q <= 1'b1;
            hold_byte_q <= bus.host_byte;
         end else if (grant_host) begin
            hold_full_q <= 1'b0;
         end
         if (drop)             ovf_q <= 1'b1;
         else if (bus.ovf_clr) ovf_q <= 1'b0;
         if (grant_host)       host_last_q <= 1'b1;
         else if (grant_aux)   host_last_q <= 1'b0;
         clr_cnt_q <= (state_q == S_CLEAR) ? clr_cnt_q + 4'd1 : 4'd0;
         wr_ptr_q  <= wr_ptr_d;
         if (wr_en) buf_q[wr_addr] <= wr_data;
         rd_data_q <= buf_q[bus.rd_addr];
      end
   end
endmodule

// File: tb/tb_text_buf_arbiter.sv
// Directed bench for text_buf_arbiter: host text, control characters,
// host/aux round robin, clear sequence and overflow.
module tb_text_buf_arbiter;
   logic CLK12M = 1'b0;
   logic nrst   = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q [$];

   text_buf_arbiter_if bus ();

   text_buf_arbiter #(.DEPTH(16), .FILL(8'h20)) dut (
      .CLK12M (CLK12M),
      .nrst   (nrst),
      .bus    (bus)
   );

   always #42 CLK12M = ~CLK12M;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK12M);
      nrst = 1'b0;
      repeat (2) @(negedge CLK12M);
      nrst = 1'b1;
   endtask

   // Strobe one byte, then allow the service edge to pass.
   task automatic host_send(input logic [7:0] b);
      @(negedge CLK12M);
      bus.host_valid = 1'b1;
      bus.host_byte  = b;
      @(negedge CLK12M);
      bus.host_valid = 1'b0;
      @(negedge CLK12M);
   endtask

   task automatic read_check(input logic [3:0] addr, input logic [7:0] exp);
      logic [7:0] e;
      bus.rd_addr = addr;
      exp_q.push_back(exp);
      @(negedge CLK12M);
      e = exp_q.pop_front();
      chk($sformatf("rd[%0d]", addr), bus.rd_data, e);
   endtask

   initial begin
      int busy_cnt;
      int idle_grant_seen;
      bus.host_valid = 1'b0;
      bus.host_byte  = 8'h00;
      bus.aux_req    = 1'b0;
      bus.aux_ptr    = 4'd0;
      bus.aux_char   = 8'h00;
      bus.rd_addr    = 4'd0;
      bus.ovf_clr    = 1'b0;

      // Reset state
      do_reset();
      #1;
      chk("rst_wr_ptr", {4'd0, bus.wr_ptr}, 8'd0);
      chk("rst_ovf", {7'd0, bus.ovf}, 8'd0);
      chk("rst_busy", {7'd0, bus.busy}, 8'd0);
      chk("rst_grant", {7'd0, bus.aux_grant}, 8'd0);
      chk("rst_rd_data", bus.rd_data, 8'h20);
      for (int i = 0; i < 16; i++) read_check(4'(i), 8'h20);

      // "HI", CR, "Y"
      host_send("H"); host_send("I"); host_send(8'h0D); host_send("Y");
      read_check(4'd0, "Y");
      read_check(4'd1, "I");
      chk("hi_wr_ptr", {4'd0, bus.wr_ptr}, 8'd1);

      // 17 printable bytes wrap the cursor, then two backspaces
      host_send(8'h0D);
      for (int i = 0; i < 17; i++) host_send(8'(8'h41 + i));
      read_check(4'd0, "Q");
      read_check(4'd1, "B");
      read_check(4'd14, "O");
      chk("wrap_wr_ptr", {4'd0, bus.wr_ptr}, 8'd1);
      host_send(8'h08); host_send(8'h08);
      read_check(4'd0, 8'h20);
      read_check(4'd15, 8'h20);
      read_check(4'd1, "B");
      chk("bs_wr_ptr", {4'd0, bus.wr_ptr}, 8'd15);

      // Contention from reset: aux wins first, host next cycle
      do_reset();
      bus.host_valid = 1'b1;
      bus.host_byte  = "Z";
      @(negedge CLK12M);
      bus.host_valid = 1'b0;
      bus.aux_req    = 1'b1;
      bus.aux_ptr    = 4'd5;
      bus.aux_char   = "X";
      #1;
      chk("rr_aux_first", {7'd0, bus.aux_grant}, 8'd1);
      @(negedge CLK12M);
      bus.aux_req = 1'b0;
      #1;
      chk("rr_host_pending_ptr", {4'd0, bus.wr_ptr}, 8'd0);
      @(negedge CLK12M);
      chk("rr_host_ptr", {4'd0, bus.wr_ptr}, 8'd1);
      read_check(4'd0, "Z");
      read_check(4'd5, "X");

      // Aux held while a host byte arrives: host wins the contended cycle
      bus.aux_req    = 1'b1;
      bus.aux_ptr    = 4'd6;
      bus.aux_char   = "W";
      bus.host_valid = 1'b1;
      bus.host_byte  = "K";
      #1;
      chk("hold_aux_alone", {7'd0, bus.aux_grant}, 8'd1);
      @(negedge CLK12M);
      bus.host_valid = 1'b0;
      #1;
      chk("hold_host_wins", {7'd0, bus.aux_grant}, 8'd0);
      @(negedge CLK12M);
      #1;
      chk("hold_aux_next", {7'd0, bus.aux_grant}, 8'd1);
      @(negedge CLK12M);
      bus.aux_req = 1'b0;
      read_check(4'd1, "K");
      read_check(4'd6, "W");

      // Fill the buffer, then ESC with aux and two host strobes during CLEAR
      host_send(8'h0D);
      for (int i = 0; i < 16; i++) host_send(8'(8'h61 + i));
      read_check(4'd9, "j");
      @(negedge CLK12M);
      bus.host_valid = 1'b1;
      bus.host_byte  = 8'h1B;
      busy_cnt = 0;
      idle_grant_seen = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         @(negedge CLK12M);
         bus.host_valid = 1'b0;
         if (cyc == 2) begin
            bus.aux_req  = 1'b1;
            bus.aux_ptr  = 4'd3;
            bus.aux_char = "M";
         end
         if (cyc == 3) begin bus.host_valid = 1'b1; bus.host_byte = "T"; end
         if (cyc == 5) begin bus.host_valid = 1'b1; bus.host_byte = "U"; end
         #1;
         if (cyc == 0) chk("esc_busy_service", {7'd0, bus.busy}, 8'd0);
         if (bus.busy) begin
            busy_cnt++;
            chk("clr_no_grant", {7'd0, bus.aux_grant}, 8'd0);
         end else if (busy_cnt > 0 && idle_grant_seen == 0) begin
            idle_grant_seen = 1;
            chk("clr_idle_grant", {7'd0, bus.aux_grant}, 8'd1);
         end
      end
      @(negedge CLK12M);
      bus.aux_req = 1'b0;
      chk("clr_busy_cycles", 8'(busy_cnt), 8'd16);
      chk("clr_idle_seen", 8'(idle_grant_seen), 8'd1);
      chk("clr_ovf", {7'd0, bus.ovf}, 8'd1);
      chk("clr_wr_ptr", {4'd0, bus.wr_ptr}, 8'd1);
      read_check(4'd0, "T");
      read_check(4'd3, "M");
      for (int i = 1; i < 16; i++) if (i != 3) read_check(4'(i), 8'h20);

      bus.ovf_clr = 1'b1;
      @(negedge CLK12M);
      bus.ovf_clr = 1'b0;
      chk("ovf_cleared", {7'd0, bus.ovf}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
